// File: rtl/l2_port_arbiter_pkg.sv
// Shared types for the L2 port arbiter: FSM state encoding, grant side,
// default widths and the saturating increment used by the optional
// performance counters (enabled with ARB_PERF_CNT_EN).
package l2_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_IBUSY = 2'd1,
        ARB_DBUSY = 2'd2
    } arb_state_t;

    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } grant_t;

    localparam int unsigned ARB_ADDR_W = 32;
    localparam int unsigned ARB_LINE_W = 256;
    localparam int unsigned ARB_CNT_W  = 32;

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [ARB_CNT_W-1:0] sat_inc(input logic [ARB_CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/l2_port_arbiter.sv
// l2_port_arbiter: registered grant FSM sequencing the single L2 port
// between the L1 icache and the L1 dcache. Round-robin on conflict, grant
// held until L2 completes. Optional performance counters are built when
// ARB_PERF_CNT_EN is defined.
module l2_port_arbiter
    import l2_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = ARB_ADDR_W,
    parameter int unsigned LINE_W = ARB_LINE_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic              d_resp,
    output logic              l2_read,
    output logic              l2_write,
    output logic [ADDR_W-1:0] l2_addr,
    output logic [LINE_W-1:0] l2_wdata,
`ifdef ARB_PERF_CNT_EN
    output logic [ARB_CNT_W-1:0] i_grant_cnt,
    output logic [ARB_CNT_W-1:0] d_grant_cnt,
    output logic [ARB_CNT_W-1:0] conflict_cnt,
`endif
    input  logic              l2_resp
);

    arb_state_t state, state_next;
    grant_t     last_grant;

    logic i_req;
    logic d_req;
    logic conflict;

    assign i_req    = i_read;
    assign d_req    = d_read | d_write;
    assign conflict = (state == ARB_IDLE) && i_req && d_req;

    // Next-state selection: round-robin against last_grant on conflict,
    // BUSY states only leave on the L2 completion pulse.
    always_comb begin
        state_next = state;
        unique case (state)
            ARB_IDLE: begin
                if (i_req && d_req)
                    state_next = (last_grant == GRANT_D) ? ARB_IBUSY : ARB_DBUSY;
                else if (i_req)
                    state_next = ARB_IBUSY;
                else if (d_req)
                    state_next = ARB_DBUSY;
            end
            ARB_IBUSY,
            ARB_DBUSY: begin
                if (l2_resp)
                    state_next = ARB_IDLE;
            end
            default: state_next = ARB_IDLE;
        endcase
    end

    // State register and grant history; last_grant moves only on BUSY entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ARB_IDLE;
            last_grant <= GRANT_D;
        end else begin
            state <= state_next;
            if (state == ARB_IDLE && state_next == ARB_IBUSY)
                last_grant <= GRANT_I;
            else if (state == ARB_IDLE && state_next == ARB_DBUSY)
                last_grant <= GRANT_D;
        end
    end

    // L2 command decode from registered state; responses are steered to the
    // granted side combinationally in the completion cycle.
    always_comb begin
        l2_read  = 1'b0;
        l2_write = 1'b0;
        l2_addr  = '0;
        i_resp   = 1'b0;
        d_resp   = 1'b0;
        unique case (state)
            ARB_IBUSY: begin
                l2_read = 1'b1;
                l2_addr = i_addr;
                i_resp  = l2_resp;
            end
            ARB_DBUSY: begin
                // Write takes precedence if both are (illegally) raised.
                l2_read  = d_read & ~d_write;
                l2_write = d_write;
                l2_addr  = d_addr;
                d_resp   = l2_resp;
            end
            default: ;
        endcase
    end

    assign l2_wdata = d_wdata;

`ifdef ARB_PERF_CNT_EN
    // Saturating grant and conflict counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i_grant_cnt  <= '0;
            d_grant_cnt  <= '0;
            conflict_cnt <= '0;
        end else begin
            if (state == ARB_IDLE && state_next == ARB_IBUSY)
                i_grant_cnt <= sat_inc(i_grant_cnt);
            if (state == ARB_IDLE && state_next == ARB_DBUSY)
                d_grant_cnt <= sat_inc(d_grant_cnt);
            if (conflict)
                conflict_cnt <= sat_inc(conflict_cnt);
        end
    end
`endif

    // The dcache must never request a read and a write-back together.
    a_no_dual_d_cmd: assert property (@(posedge clk) disable iff (rst) !(d_read && d_write));

endmodule

// File: tb/tb_l2_port_arbiter.sv
// Directed testbench for l2_port_arbiter. Inputs change 1 time unit after
// the rising edge; outputs are checked in the same window, away from edges.
module tb_l2_port_arbiter;
    import l2_port_arbiter_pkg::*;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned LINE_W = 256;

    logic              clk;
    logic              rst;
    logic              i_read;
    logic [ADDR_W-1:0] i_addr;
    logic              i_resp;
    logic              d_read;
    logic              d_write;
    logic [ADDR_W-1:0] d_addr;
    logic [LINE_W-1:0] d_wdata;
    logic              d_resp;
    logic              l2_read;
    logic              l2_write;
    logic [ADDR_W-1:0] l2_addr;
    logic [LINE_W-1:0] l2_wdata;
    logic              l2_resp;
`ifdef ARB_PERF_CNT_EN
    logic [31:0] i_grant_cnt;
    logic [31:0] d_grant_cnt;
    logic [31:0] conflict_cnt;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    l2_port_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .i_read   (i_read),
        .i_addr   (i_addr),
        .i_resp   (i_resp),
        .d_read   (d_read),
        .d_write  (d_write),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_resp   (d_resp),
        .l2_read  (l2_read),
        .l2_write (l2_write),
        .l2_addr  (l2_addr),
        .l2_wdata (l2_wdata),
`ifdef ARB_PERF_CNT_EN
        .i_grant_cnt  (i_grant_cnt),
        .d_grant_cnt  (d_grant_cnt),
        .conflict_cnt (conflict_cnt),
`endif
        .l2_resp  (l2_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [LINE_W-1:0] got, input logic [LINE_W-1:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_cmd(input string tag, input logic rd, input logic wr, input logic [ADDR_W-1:0] addr);
        check_eq({tag, ".l2_read"},  l2_read,  rd);
        check_eq({tag, ".l2_write"}, l2_write, wr);
        check_eq({tag, ".l2_addr"},  l2_addr,  addr);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        logic [LINE_W-1:0] ones;
        ones    = '1;
        rst     = 1'b1;
        i_read  = 1'b0;
        i_addr  = '0;
        d_read  = 1'b0;
        d_write = 1'b0;
        d_addr  = '0;
        d_wdata = '0;
        l2_resp = 1'b0;

        // Reset state
        tick();
        tick();
        check_cmd("rst", 1'b0, 1'b0, 32'h0);
        check_eq("rst.i_resp", i_resp, 1'b0);
        check_eq("rst.d_resp", d_resp, 1'b0);
        rst = 1'b0;

        // 1: single icache fill, command one cycle after request, resp at +4
        i_read = 1'b1;
        i_addr = 32'h0000_0060;
        #1;
        check_eq("t1.l2_read_idle", l2_read, 1'b0);
        tick();
        check_cmd("t1.cmd", 1'b1, 1'b0, 32'h60);
        tick();
        tick();
        tick();
        l2_resp = 1'b1;
        #1;
        check_eq("t1.i_resp", i_resp, 1'b1);
        check_eq("t1.d_resp", d_resp, 1'b0);
        tick();
        l2_resp = 1'b0;
        i_read  = 1'b0;
        check_cmd("t1.idle", 1'b0, 1'b0, 32'h0);
        check_eq("t1.i_resp_after", i_resp, 1'b0);

        // 2: simultaneous requests after reset -> icache first, then dcache
        pulse_reset();
        i_read = 1'b1;
        i_addr = 32'h0000_0100;
        d_read = 1'b1;
        d_addr = 32'h0000_0200;
        tick();
        check_cmd("t2.i_cmd", 1'b1, 1'b0, 32'h100);
        tick();
        l2_resp = 1'b1;
        #1;
        check_eq("t2.i_resp", i_resp, 1'b1);
        check_eq("t2.d_resp_pending", d_resp, 1'b0);
        tick();
        l2_resp = 1'b0;
        i_read  = 1'b0;
        check_cmd("t2.gap", 1'b0, 1'b0, 32'h0);
        tick();
        check_cmd("t2.d_cmd", 1'b1, 1'b0, 32'h200);
        l2_resp = 1'b1;
        #1;
        check_eq("t2.d_resp", d_resp, 1'b1);
        check_eq("t2.i_resp_other", i_resp, 1'b0);
        tick();
        l2_resp = 1'b0;
        d_read  = 1'b0;
        tick();
        check_cmd("t2.idle", 1'b0, 1'b0, 32'h0);

        // 3: dcache write-back; request dropped mid-transaction keeps grant
        d_write = 1'b1;
        d_addr  = 32'h0000_1000;
        d_wdata = ones;
        tick();
        check_cmd("t3.cmd", 1'b0, 1'b1, 32'h1000);
        check_eq("t3.l2_wdata", l2_wdata, ones);
        tick();
        check_cmd("t3.hold", 1'b0, 1'b1, 32'h1000);
        d_write = 1'b0;
        tick();
        check_eq("t3.still_granted_rd", l2_read, 1'b0);
        check_eq("t3.still_granted_addr", l2_addr, 32'h1000);
        l2_resp = 1'b1;
        #1;
        check_eq("t3.d_resp", d_resp, 1'b1);
        tick();
        l2_resp = 1'b0;
        check_cmd("t3.idle", 1'b0, 1'b0, 32'h0);

        // 4: four back-to-back conflicts alternate I,D,I,D
        pulse_reset();
        i_read = 1'b1;
        i_addr = 32'h0000_0A00;
        d_read = 1'b1;
        d_addr = 32'h0000_0B00;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (k % 2 == 0)
                check_cmd($sformatf("t4.grant%0d_I", k), 1'b1, 1'b0, 32'h0A00);
            else
                check_cmd($sformatf("t4.grant%0d_D", k), 1'b1, 1'b0, 32'h0B00);
            l2_resp = 1'b1;
            #1;
            check_eq($sformatf("t4.i_resp%0d", k), i_resp, (k % 2 == 0));
            check_eq($sformatf("t4.d_resp%0d", k), d_resp, (k % 2 == 1));
            tick();
            l2_resp = 1'b0;
            if (k == 3) begin
                i_read = 1'b0;
                d_read = 1'b0;
            end
            check_eq($sformatf("t4.gap%0d", k), l2_read, 1'b0);
        end
        tick();
        check_cmd("t4.idle", 1'b0, 1'b0, 32'h0);
`ifdef ARB_PERF_CNT_EN
        check_eq("t4.conflict_cnt", conflict_cnt, 32'd4);
        check_eq("t4.i_grant_cnt",  i_grant_cnt,  32'd2);
        check_eq("t4.d_grant_cnt",  d_grant_cnt,  32'd2);
`endif

        // 5: asynchronous reset while in DBUSY
        d_write = 1'b1;
        d_addr  = 32'h0000_0300;
        tick();
        check_cmd("t5.busy", 1'b0, 1'b1, 32'h300);
        rst = 1'b1;
        #1;
        check_cmd("t5.async", 1'b0, 1'b0, 32'h0);
        l2_resp = 1'b1;
        #1;
        check_eq("t5.d_resp", d_resp, 1'b0);
        l2_resp = 1'b0;
        d_write = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        check_cmd("t5.idle", 1'b0, 1'b0, 32'h0);

        // 6: stray l2_resp while idle is ignored
        l2_resp = 1'b1;
        #1;
        check_eq("t6.i_resp", i_resp, 1'b0);
        check_eq("t6.d_resp", d_resp, 1'b0);
        tick();
        l2_resp = 1'b0;
        check_cmd("t6.idle", 1'b0, 1'b0, 32'h0);
        // Arbiter still serves a normal request afterwards
        d_read = 1'b1;
        d_addr = 32'h0000_0440;
        tick();
        check_cmd("t6.d_cmd", 1'b1, 1'b0, 32'h440);
        l2_resp = 1'b1;
        #1;
        check_eq("t6.d_resp_ok", d_resp, 1'b1);
        tick();
        l2_resp = 1'b0;
        d_read  = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
